// File: rtl/mac_stream_packer.sv
// Packs a (bias, N) command plus separate 8-bit weight/activation streams into the
// MAC's 16-bit AXI-Stream input packet: bias beat, then N {weight, activation} beats.
module mac_stream_packer #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             CMD_TVALID,
    output logic             CMD_TREADY,
    input  logic [15:0]      CMD_BIAS,
    input  logic [LEN_W-1:0] CMD_LEN,
    input  logic             W_TVALID,
    output logic             W_TREADY,
    input  logic [7:0]       W_TDATA,
    input  logic             A_TVALID,
    output logic             A_TREADY,
    input  logic [7:0]       A_TDATA,
    output logic             M_AXIS_TVALID,
    input  logic             M_AXIS_TREADY,
    output logic [15:0]      M_AXIS_TDATA,
    output logic             M_AXIS_TLAST,
    output logic             BUSY
);

    localparam int unsigned DATA_W = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PAIRS = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   remaining_nxt;

    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_last;
    logic               busy;

    logic               slot_free;
    logic               cmd_ready_c;
    logic               pair_ready_c;
    logic               cmd_fire;
    logic               last_handoff;
    logic               load;
    logic [DATA_W-1:0]  load_data;
    logic               load_last;

    assign slot_free    = !out_valid || M_AXIS_TREADY;
    assign cmd_fire     = CMD_TVALID && cmd_ready_c;
    assign last_handoff = out_valid && M_AXIS_TREADY && out_last;

    // Next-state, ready generation and beat selection for the output slot.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        load          = 1'b0;
        load_data     = '0;
        load_last     = 1'b0;
        cmd_ready_c   = 1'b0;
        pair_ready_c  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_c = slot_free && !ARESET;
                if (CMD_TVALID && cmd_ready_c) begin
                    load          = 1'b1;
                    load_data     = CMD_BIAS;
                    load_last     = (CMD_LEN == '0);
                    remaining_nxt = CMD_LEN;
                    if (CMD_LEN != '0) begin
                        state_nxt = PAIRS;
                    end
                end
            end
            PAIRS: begin
                // Weight and activation are only ever taken together.
                pair_ready_c = slot_free && W_TVALID && A_TVALID && !ARESET;
                if (pair_ready_c) begin
                    load          = 1'b1;
                    load_data     = {W_TDATA, A_TDATA};
                    load_last     = (remaining == LEN_W'(1));
                    remaining_nxt = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and remaining-pair counter.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Single output beat slot; data and last hold while stalled.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (M_AXIS_TREADY) begin
            out_valid <= 1'b0;
        end
    end

    // A command accepted on the last handoff keeps BUSY high without a gap.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            busy <= 1'b0;
        end else if (cmd_fire) begin
            busy <= 1'b1;
        end else if (last_handoff) begin
            busy <= 1'b0;
        end
    end

    assign CMD_TREADY    = cmd_ready_c;
    assign W_TREADY      = pair_ready_c;
    assign A_TREADY      = pair_ready_c;
    assign M_AXIS_TVALID = out_valid;
    assign M_AXIS_TDATA  = out_data;
    assign M_AXIS_TLAST  = out_last;
    assign BUSY          = busy;

endmodule

// File: tb/tb_mac_stream_packer.sv
// Scoreboard bench for mac_stream_packer: expected beats are queued as stimulus is
// driven and compared, in order, as the output port hands them off.
module tb_mac_stream_packer;

    localparam int unsigned LEN_W = 16;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic             CMD_TVALID;
    logic             CMD_TREADY;
    logic [15:0]      CMD_BIAS;
    logic [LEN_W-1:0] CMD_LEN;
    logic             W_TVALID;
    logic             W_TREADY;
    logic [7:0]       W_TDATA;
    logic             A_TVALID;
    logic             A_TREADY;
    logic [7:0]       A_TDATA;
    logic             M_AXIS_TVALID;
    logic             M_AXIS_TREADY;
    logic [15:0]      M_AXIS_TDATA;
    logic             M_AXIS_TLAST;
    logic             BUSY;

    always #5 ACLK = ~ACLK;

    mac_stream_packer #(.LEN_W(LEN_W)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .CMD_TVALID    (CMD_TVALID),
        .CMD_TREADY    (CMD_TREADY),
        .CMD_BIAS      (CMD_BIAS),
        .CMD_LEN       (CMD_LEN),
        .W_TVALID      (W_TVALID),
        .W_TREADY      (W_TREADY),
        .W_TDATA       (W_TDATA),
        .A_TVALID      (A_TVALID),
        .A_TREADY      (A_TREADY),
        .A_TDATA       (A_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .BUSY          (BUSY)
    );

    logic [16:0] exp_q[$];
    int          beat_cyc[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          w_fires  = 0;
    int          a_fires  = 0;
    int          join_err = 0;
    int          hold_err = 0;
    bit          w_ready_seen = 1'b0;
    bit          prev_stall   = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;
    logic [16:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor plus handshake-rule bookkeeping, sampled mid-cycle.
    always @(negedge ACLK) begin
        cyc++;
        if (!ARESET) begin
            if (W_TREADY !== A_TREADY) join_err++;
            if (W_TREADY && !(W_TVALID && A_TVALID)) join_err++;
            if (W_TREADY) w_ready_seen = 1'b1;
            if (W_TVALID && W_TREADY) w_fires++;
            if (A_TVALID && A_TREADY) a_fires++;
            if (prev_stall && (!M_AXIS_TVALID || M_AXIS_TDATA !== prev_data ||
                               M_AXIS_TLAST !== prev_last)) hold_err++;
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_data  = M_AXIS_TDATA;
            prev_last  = M_AXIS_TLAST;
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {15'd0, M_AXIS_TLAST, M_AXIS_TDATA}, 32'hFFFF_FFFF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("beat_data", 32'(M_AXIS_TDATA), 32'(mon_exp[15:0]));
                    check("beat_last", 32'(M_AXIS_TLAST), 32'(mon_exp[16]));
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] bias, input logic [LEN_W-1:0] n);
        bit fired = 1'b0;
        CMD_BIAS   = bias;
        CMD_LEN    = n;
        CMD_TVALID = 1'b1;
        exp_q.push_back({(n == '0), bias});
        for (int i = 0; i < 100 && !fired; i++) begin
            @(negedge ACLK);
            fired = CMD_TVALID && CMD_TREADY;
            tick();
        end
        CMD_TVALID = 1'b0;
        if (!fired) check("cmd_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_pair(input logic [7:0] w, input logic [7:0] a,
                             input logic [15:0] exp_word, input logic last);
        bit fired = 1'b0;
        W_TDATA  = w;
        A_TDATA  = a;
        W_TVALID = 1'b1;
        A_TVALID = 1'b1;
        exp_q.push_back({last, exp_word});
        for (int i = 0; i < 100 && !fired; i++) begin
            @(negedge ACLK);
            fired = W_TVALID && W_TREADY;
            tick();
        end
        W_TVALID = 1'b0;
        A_TVALID = 1'b0;
        if (!fired) check("pair_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge ACLK);
            done = !BUSY && !M_AXIS_TVALID && (exp_q.size() == 0);
            tick();
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  w0;
        int  a0;
        bit  pat[6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset with all sources asserting valid: nothing may be ready or valid.
        ARESET        = 1'b1;
        CMD_TVALID    = 1'b1;
        CMD_BIAS      = 16'h1111;
        CMD_LEN       = 16'd2;
        W_TVALID      = 1'b1;
        W_TDATA       = 8'h22;
        A_TVALID      = 1'b1;
        A_TDATA       = 8'h33;
        M_AXIS_TREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("reset_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        check("reset_tlast", 32'(M_AXIS_TLAST), 32'd0);
        check("reset_tdata", 32'(M_AXIS_TDATA), 32'd0);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_cmd_tready", 32'(CMD_TREADY), 32'd0);
        check("reset_wa_tready", {30'd0, W_TREADY, A_TREADY}, 32'd0);
        CMD_TVALID = 1'b0;
        W_TVALID   = 1'b0;
        A_TVALID   = 1'b0;
        tick();
        ARESET = 1'b0;
        tick();

        // Bias -1028, three pairs, steady ready.
        send_cmd(16'(-1028), 16'd3);
        check("t1_busy_set", 32'(BUSY), 32'd1);
        send_pair(8'(-122), 8'(-15), 16'h86F1, 1'b0);
        send_pair(8'(119),  8'(-3),  16'h77FD, 1'b0);
        send_pair(8'(-107), 8'(13),  16'h950D, 1'b1);
        wait_idle();
        check("t1_busy_clear", 32'(BUSY), 32'd0);

        // Bias 5000 with the most negative pair.
        send_cmd(16'd5000, 16'd1);
        send_pair(8'h80, 8'h80, 16'h8080, 1'b1);
        wait_idle();

        // Zero-length packet: bias only, pair streams never consumed.
        w_ready_seen = 1'b0;
        W_TDATA  = 8'h44;
        A_TDATA  = 8'h55;
        W_TVALID = 1'b1;
        A_TVALID = 1'b1;
        send_cmd(16'd7, 16'd0);
        W_TVALID = 1'b1;
        A_TVALID = 1'b1;
        wait_idle();
        W_TVALID = 1'b0;
        A_TVALID = 1'b0;
        check("t3_no_wa_ready", 32'(w_ready_seen), 32'd0);
        check("t3_busy_clear", 32'(BUSY), 32'd0);

        // Backpressure pattern on the output while a two-pair packet flows.
        w0 = w_fires;
        a0 = a_fires;
        fork
            begin
                send_cmd(16'h1234, 16'd2);
                send_pair(8'h11, 8'h22, 16'h1122, 1'b0);
                send_pair(8'h33, 8'h44, 16'h3344, 1'b1);
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    M_AXIS_TREADY = pat[i];
                    tick();
                end
                M_AXIS_TREADY = 1'b1;
            end
        join
        wait_idle();
        check("t4_w_consumed", 32'(w_fires - w0), 32'd2);
        check("t4_a_consumed", 32'(a_fires - a0), 32'd2);

        // Weight arrives three cycles ahead of its activation.
        send_cmd(16'h0100, 16'd1);
        w0 = w_fires;
        W_TDATA  = 8'h5A;
        W_TVALID = 1'b1;
        A_TVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("t5_w_waits", 32'(W_TREADY), 32'd0);
            tick();
        end
        exp_q.push_back({1'b1, 16'h5AA5});
        A_TDATA  = 8'hA5;
        A_TVALID = 1'b1;
        @(negedge ACLK);
        check("t5_joint_fire", {30'd0, W_TREADY, A_TREADY}, 32'd3);
        tick();
        W_TVALID = 1'b0;
        A_TVALID = 1'b0;
        check("t5_single_w", 32'(w_fires - w0), 32'd1);
        wait_idle();

        // Back-to-back commands must give five consecutive beats.
        beat_cyc.delete();
        send_cmd(16'hAAAA, 16'd2);
        send_pair(8'h01, 8'h02, 16'h0102, 1'b0);
        send_pair(8'h03, 8'h04, 16'h0304, 1'b1);
        send_cmd(16'hBBBB, 16'd1);
        send_pair(8'h05, 8'h06, 16'h0506, 1'b1);
        wait_idle();
        check("t6_beat_count", 32'(beat_cyc.size()), 32'd5);
        if (beat_cyc.size() == 5) begin
            check("t6_no_bubble", 32'(beat_cyc[4] - beat_cyc[0]), 32'd4);
        end

        // Reset while the second pair is being offered drops the packet.
        send_cmd(16'hCCCC, 16'd3);
        send_pair(8'h10, 8'h20, 16'h1020, 1'b0);
        W_TDATA  = 8'h30;
        A_TDATA  = 8'h40;
        W_TVALID = 1'b1;
        A_TVALID = 1'b1;
        ARESET   = 1'b1;
        #1;
        check("t7_tvalid_drop", 32'(M_AXIS_TVALID), 32'd0);
        check("t7_tlast_drop", 32'(M_AXIS_TLAST), 32'd0);
        check("t7_busy_drop", 32'(BUSY), 32'd0);
        check("t7_wa_tready", {30'd0, W_TREADY, A_TREADY}, 32'd0);
        exp_q.delete();
        W_TVALID = 1'b0;
        A_TVALID = 1'b0;
        tick();
        tick();
        ARESET = 1'b0;
        tick();
        send_cmd(16'hDDDD, 16'd1);
        send_pair(8'h07, 8'h08, 16'h0708, 1'b1);
        wait_idle();

        check("join_rule", 32'(join_err), 32'd0);
        check("stall_hold", 32'(hold_err), 32'd0);
        check("wa_balance", 32'(w_fires), 32'(a_fires));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
